// File: rtl/datamover_realigner_if.sv
// Valid/ready word stream with byte strobes, shared by the streamer and the engine.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/datamover_realigner.sv
// Byte realigner: drops the leading offset bytes of an unaligned word stream
// and re-packs the remainder into aligned output words.
module datamover_realigner #(
  parameter int unsigned DW    = 256,
  parameter int unsigned LEN_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic [$clog2(DW/8)-1:0]  offset_i,
  input  logic [LEN_W-1:0]         len_i,
  hwpe_stream_intf_stream.sink     data_in,
  hwpe_stream_intf_stream.source   data_out,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned OW = $clog2(NB);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRIME  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [OW-1:0]    off_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] ld_q;
  logic [DW-1:0]    prev_q;
  logic [DW-1:0]    out_q;
  logic             full_q;

  logic             in_rdy_c;
  logic             in_hs_c;
  logic             out_hs_c;
  logic             load_c;
  logic             start_c;
  logic [DW-1:0]    shifted_c;
  logic [DW-1:0]    comb_c;

  assign start_c   = (state_q == IDLE) && start_i;
  assign in_hs_c   = data_in.valid && in_rdy_c;
  assign out_hs_c  = full_q && data_out.ready;
  assign load_c    = in_hs_c && (state_q == STREAM);

  // Offset 0 never primes, so the live word passes through untouched.
  assign shifted_c = DW'({data_in.data, prev_q} >> {off_q, 3'b000});
  assign comb_c    = (off_q == '0) ? data_in.data : shifted_c;

  assign data_in.ready  = in_rdy_c;
  assign data_out.valid = full_q;
  assign data_out.data  = out_q;
  assign data_out.strb  = '1;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_rdy_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0)           state_d = DONE;
          else if (offset_i != '0)   state_d = PRIME;
          else                       state_d = STREAM;
        end
      end
      PRIME: begin
        in_rdy_c = 1'b1;
        if (data_in.valid) state_d = STREAM;
      end
      STREAM: begin
        // Accept only while the output slot frees up and words remain to be loaded.
        in_rdy_c = (!full_q || data_out.ready) && (ld_q != len_q);
        if (out_hs_c && (cnt_q == len_q - LEN_W'(1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      ld_q   <= '0;
      prev_q <= '0;
      out_q  <= '0;
      full_q <= 1'b0;
    end else if (clear_i) begin
      off_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      ld_q   <= '0;
      prev_q <= '0;
      out_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (start_c && (len_i != '0)) begin
        off_q <= offset_i;
        len_q <= len_i;
        cnt_q <= '0;
        ld_q  <= '0;
      end else begin
        if (out_hs_c) cnt_q <= cnt_q + LEN_W'(1);
        if (load_c)   ld_q  <= ld_q + LEN_W'(1);
      end
      if (in_hs_c) prev_q <= data_in.data;
      if (load_c) begin
        out_q  <= comb_c;
        full_q <= 1'b1;
      end else if (out_hs_c) begin
        full_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_datamover_realigner.sv
// Directed bench for datamover_realigner at DW=64 with a byte-stream scoreboard.
module tb_datamover_realigner;
  localparam int unsigned DW    = 64;
  localparam int unsigned LEN_W = 16;

  logic             clk;
  bit               clk_en = 1'b1;
  logic             rst_n;
  logic             clear;
  logic             start;
  logic [2:0]       offset;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) din_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) dout_if ();

  datamover_realigner #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (clear),
    .start_i  (start),
    .offset_i (offset),
    .len_i    (len),
    .data_in  (din_if),
    .data_out (dout_if),
    .busy_o   (busy),
    .done_o   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 if (clk_en) clk = ~clk;
  end

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int in_hs, out_cnt, done_seen, run, max_run;
  bit rnd_ready, ready_force;
  bit hold_pend;
  logic [DW-1:0] hold_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    din_if.valid = (src_q.size() > 0);
    din_if.data  = (src_q.size() > 0) ? src_q[0] : '0;
  endtask

  // One clock: observe handshakes at the falling edge, update drivers just after the rising edge.
  task automatic cycle();
    logic in_fire, out_fire;
    @(negedge clk);
    in_fire  = din_if.valid && din_if.ready;
    out_fire = dout_if.valid && dout_if.ready;
    if (done === 1'b1) done_seen++;
    if (hold_pend) begin
      chk("stall_valid", 64'(dout_if.valid), 64'd1);
      chk("stall_data", dout_if.data, hold_data);
    end
    if (dout_if.valid === 1'b1) run++; else run = 0;
    if (run > max_run) max_run = run;
    if (out_fire) begin
      out_cnt++;
      if (exp_q.size() == 0) chk("out_extra", 64'(exp_q.size()), 64'd1);
      else                   chk("out_data", dout_if.data, exp_q.pop_front());
    end
    hold_pend = dout_if.valid && !dout_if.ready;
    hold_data = dout_if.data;
    @(posedge clk);
    #1;
    if (in_fire) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      in_hs++;
    end
    drive_src();
    dout_if.ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
  endtask

  // Queue the input words of a job and the output words the byte stream implies.
  task automatic prep_job(input int off, input int n, input int kind, output int nin);
    logic [DW-1:0] w[];
    logic [DW-1:0] e;
    int idx;
    nin = (n == 0) ? 0 : ((off != 0) ? n + 1 : n);
    w = new[nin];
    for (int i = 0; i < nin; i++) begin
      case (kind)
        0:       for (int b = 0; b < 8; b++) w[i][8*b +: 8] = 8'(8*i + b);
        1:       w[i] = {$urandom(), $urandom()};
        default: w[i] = 64'(i);
      endcase
      src_q.push_back(w[i]);
    end
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 8; b++) begin
        idx = off + 8*k + b;
        e[8*b +: 8] = w[idx/8][8*(idx%8) +: 8];
      end
      exp_q.push_back(e);
    end
    drive_src();
  endtask

  task automatic run_job(input int off, input int n, input int kind, input bit rnd, input int exp_run);
    int nin, d0;
    prep_job(off, n, kind, nin);
    in_hs = 0; out_cnt = 0; d0 = done_seen; run = 0; max_run = 0;
    rnd_ready = rnd; ready_force = 1'b1;
    offset = 3'(off); len = LEN_W'(n);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int t = 0; t < 400 && done_seen == d0; t++) cycle();
    chk("done_timeout", 64'(done_seen != d0), 64'd1);
    repeat (3) cycle();
    chk("done_pulses", 64'(done_seen - d0), 64'd1);
    chk("in_handshakes", 64'(in_hs), 64'(nin));
    chk("out_words", 64'(out_cnt), 64'(n));
    chk("exp_left", 64'(exp_q.size()), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    if (exp_run > 0) chk("valid_run", 64'(max_run), 64'(exp_run));
    rnd_ready = 1'b0;
  endtask

  initial begin
    int nin;
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; offset = '0; len = '0;
    din_if.valid = 1'b0; din_if.data = '0; din_if.strb = '1;
    dout_if.ready = 1'b1; ready_force = 1'b1; rnd_ready = 1'b0;
    hold_pend = 1'b0; hold_data = '0;
    in_hs = 0; out_cnt = 0; done_seen = 0; run = 0; max_run = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_ready", 64'(din_if.ready), 64'd0);
    chk("rst_valid", 64'(dout_if.valid), 64'd0);
    chk("rst_strb",  64'(dout_if.strb), 64'hFF);
    #2 rst_n = 1'b1;
    cycle();

    run_job(3, 1, 0, 1'b0, 0);
    run_job(0, 4, 2, 1'b0, 4);
    run_job(5, 8, 0, 1'b1, 0);
    run_job(2, 5, 1, 1'b1, 0);
    run_job(0, 3, 1, 1'b1, 0);

    // Zero-length job: completes without touching the input.
    src_q.push_back(64'hDEAD_BEEF_0123_4567);
    drive_src();
    in_hs = 0;
    offset = 3'd0; len = '0; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("len0_done",  64'(done), 64'd1);
    chk("len0_busy",  64'(busy), 64'd1);
    chk("len0_ready", 64'(din_if.ready), 64'd0);
    cycle();
    chk("len0_done_end", 64'(done), 64'd0);
    chk("len0_busy_end", 64'(busy), 64'd0);
    chk("len0_ready_end", 64'(din_if.ready), 64'd0);
    chk("len0_in_hs", 64'(in_hs), 64'd0);
    src_q.delete();
    drive_src();
    cycle();

    // Clear mid-job after two delivered words.
    prep_job(2, 6, 1, nin);
    in_hs = 0; out_cnt = 0; ready_force = 1'b1;
    offset = 3'd2; len = LEN_W'(6); start = 1'b1;
    cycle();
    start = 1'b0;
    for (int t = 0; t < 100 && out_cnt < 2; t++) cycle();
    chk("clr_two_out", 64'(out_cnt), 64'd2);
    ready_force = 1'b0; dout_if.ready = 1'b0; clear = 1'b1;
    cycle();
    clear = 1'b0; hold_pend = 1'b0;
    src_q.delete(); exp_q.delete();
    drive_src();
    chk("clr_busy",  64'(busy), 64'd0);
    chk("clr_valid", 64'(dout_if.valid), 64'd0);
    chk("clr_ready", 64'(din_if.ready), 64'd0);
    ready_force = 1'b1; dout_if.ready = 1'b1;
    repeat (3) cycle();
    chk("clr_no_out", 64'(out_cnt), 64'd2);
    chk("clr_valid_later", 64'(dout_if.valid), 64'd0);
    run_job(1, 2, 1, 1'b0, 0);

    // Asynchronous reset while waiting in PRIME with the clock stopped.
    offset = 3'd7; len = LEN_W'(1); start = 1'b1;
    cycle();
    start = 1'b0;
    chk("prime_busy",  64'(busy), 64'd1);
    chk("prime_ready", 64'(din_if.ready), 64'd1);
    clk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy",  64'(busy), 64'd0);
    chk("arst_ready", 64'(din_if.ready), 64'd0);
    chk("arst_valid", 64'(dout_if.valid), 64'd0);
    chk("arst_done",  64'(done), 64'd0);
    #20 rst_n = 1'b1;
    #1 clk_en = 1'b1;
    hold_pend = 1'b0;
    repeat (2) cycle();
    run_job(7, 1, 0, 1'b0, 0);
    run_job(7, 3, 1, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/datamover_realigner.md
DATAMOVER_REALIGNER -- requirements
Module: datamover_realigner

Interface
REQ-001 SHALL have parameter DW, default 256: stream data width in bits, a multiple of 32; NB = DW/8 bytes per word.
REQ-002 SHALL have parameter LEN_W, default 16: width of the word-count configuration.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous software clear.
REQ-006 SHALL have port start_i, input, 1 bit: one-cycle job start pulse.
REQ-007 SHALL have port offset_i, input, log2(NB) bits: byte offset of the first valid byte within the first input word.
REQ-008 SHALL have port len_i, input, LEN_W bits: number of output words to produce.
REQ-009 SHALL have port data_in, hwpe_stream_intf_stream.sink, DATA_WIDTH=DW: unaligned word stream from the streamer source.
REQ-010 SHALL have port data_out, hwpe_stream_intf_stream.source, DATA_WIDTH=DW: byte-aligned stream to the engine.
REQ-011 SHALL have port busy_o, output, 1 bit: high while a job is active.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle pulse when the last output word is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, PRIME, STREAM, DONE.
REQ-014 IDLE: on start_i with len_i != 0, SHALL latch offset_i and len_i; SHALL go to PRIME if offset != 0, else to STREAM.
REQ-015 IDLE: on start_i with len_i == 0, SHALL go to DONE and consume no input.
REQ-016 PRIME: data_in.ready SHALL be 1; the first input handshake loads holding register prev; then go to STREAM.
REQ-017 STREAM: combined word = ({data_in.data, prev} >> 8*offset)[DW-1:0]; with offset 0 the output SHALL equal data_in.data unchanged.
REQ-018 STREAM: the combined word SHALL be written into a single output register when data_in.valid is 1 and the register is empty or data_out.ready is 1.
REQ-019 STREAM: data_in.ready SHALL equal (output register empty OR data_out.ready); every input handshake also loads prev.
REQ-020 Output register SHALL drive data_out.data; data_out.strb SHALL be all ones; data_out.valid SHALL be the register-full flag; data_out.valid SHALL NOT depend combinationally on data_out.ready.
REQ-021 SHALL keep an output counter cnt (LEN_W bits) that increments on each data_out handshake.
REQ-022 SHALL stop input acceptance once len words have been loaded into the output register.
REQ-023 Leave STREAM for DONE when the handshake with cnt == len-1 occurs.
REQ-024 Input words consumed per job SHALL be len+1 when offset != 0, and len when offset == 0.
REQ-025 DONE: done_o SHALL be 1 for exactly one cycle, then return to IDLE.
REQ-026 busy_o SHALL be 1 in PRIME, STREAM and DONE.
REQ-027 start_i SHALL be ignored outside IDLE.
REQ-028 Latency: first output valid SHALL occur 1 cycle after the input handshake that completes it; sustained throughput SHALL be 1 word/cycle while data_out.ready is held high.
REQ-029 Back-pressure: while data_out.valid=1 and data_out.ready=0, data_out.data SHALL be held stable and no input SHALL be consumed.
REQ-030 Once data_out.valid is asserted, it SHALL NOT deassert until the handshake completes.

Reset
REQ-031 On rst_ni low, SHALL go to IDLE asynchronously; cnt, prev, output register, latched offset and latched len SHALL be 0.
REQ-032 While in reset, data_out.valid, data_in.ready, busy_o and done_o SHALL be 0.
REQ-033 clear_i SHALL have the same effect as reset, synchronously, at the next edge, including mid-job.
REQ-034 A partially delivered output word SHALL be dropped on clear_i and SHALL NOT be presented afterwards.

Verification
REQ-035 DW=64, offset=3, len=1, inputs 0x0706050403020100 then 0x0F0E0D0C0B0A0908 -> one output 0x0A09080706050403; done_o pulses once; 2 input handshakes.
REQ-036 DW=64, offset=0, len=4, inputs 0x..00 to 0x..03, data_out.ready=1 -> outputs equal inputs in order; 4 consecutive valid cycles; 4 input handshakes.
REQ-037 DW=64, offset=5, len=8, random data_out.ready (50%) -> byte stream equals input bytes 5..68; data stable while stalled; no word lost or duplicated.
REQ-038 start_i with len_i=0 -> done_o at cycle 1 after start; data_in.ready stays 0; busy_o high for 1 cycle.
REQ-039 clear_i during STREAM after 2 of 6 words -> next cycle state IDLE, data_out.valid=0, cnt=0; a new start with offset=1, len=2 then completes correctly.
REQ-040 rst_ni asserted mid-PRIME with no clock running -> busy_o and data_in.ready drop immediately; after release a job with offset=7, len=1 produces the correct single word.
